i2c_byte_master: RTL and testbench
==================================

# i2c_byte_master

Single-master I2C transmitter/receiver that generates START, a 7-bit address plus R/W bit, one data byte, the ACK/NACK slots and STOP on an open-drain SCL/SDA pair. It is the upstream stage of the team's 8-bit I2C slave tester: it drives the bus that the slave samples. It is also used standalone to exercise any single-byte I2C target. No clock stretching and no multi-master arbitration.

## Interface
- CLKS_PER_QUARTER, 250, system clocks per SCL quarter-period (100 kHz SCL at 100 MHz clk); legal range 2..65535
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a transaction; sampled only while busy=0
- addr  in  7  target address, latched on accept
- rw  in  1  0 = write data, 1 = read one byte; latched on accept
- wr_data  in  8  byte to write, latched on accept
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse when the bus has returned to idle
- ack_err  out  1  valid with done; 1 = target NACKed address, or NACKed the data byte on a write
- rd_data  out  8  byte read; valid with done when rw=1 and ack_err=0
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- sda_i  in  1  sampled SDA line, pre-synchronised by the top level

## Operation
- Reset: state IDLE; scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rd_data=0. An asserted rst mid-transfer releases both lines immediately. No STOP is generated in that case.
- Accept: when start=1 and busy=0 at a posedge, the block latches addr, rw and wr_data and enters START. start while busy=1 is ignored.
- Every bus state is 4 quarters long, q0..q3, and each quarter lasts CLKS_PER_QUARTER clocks.
- FSM states: IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP.
- START: q0–q1 both lines released; q2 SDA low with SCL high; q3 SCL low.
- Bit slot (ADDR, DATA, ACK_A, ACK_D):
  - SCL is low in q0–q1 and released in q2–q3.
  - SDA is set at the start of q0 and held for q0–q3.
  - sda_i is sampled at the last clock of q2.
- ADDR: 8 bit slots, MSB first: addr[6:0], then rw.
- ACK_A: SDA released; sample sda_i. If 1 (NACK): ack_err=1 and go to STOP. If 0: go to DATA.
- DATA, rw=0: shift out wr_data MSB first.
- DATA, rw=1: SDA released; shift sda_i into rd_data MSB first.
- ACK_D, rw=0: SDA released; sample sda_i; ack_err=sda_i.
- ACK_D, rw=1: the master always NACKs (SDA released); ack_err is not changed.
- STOP: q0 SCL low, SDA low; q1 SCL released, SDA low; q2 SDA released; q3 both released.
- After STOP q3: return to IDLE, busy=0, done pulse.
- ack_err and rd_data hold their values until the next accept. Both clear on accept.

## Timing
- Accept to first bus edge: 1 clk. busy rises on the clk after the start sample.
- Full transaction: 80 quarters (4 START + 36 address/ACK + 36 data/ACK + 4 STOP), i.e. 80·CLKS_PER_QUARTER clks from accept to done.
- Address NACK: 44 quarters.
- SDA never changes while SCL is released, except the START q2 fall and the STOP q2 rise.
- done and busy deassertion happen in the same clk.
- start held high continuously launches back-to-back transactions. The next accept occurs on the clk after done.
- Quarter counter width: clog2(CLKS_PER_QUARTER). It wraps to 0 on the last clock of each quarter.
- Bit counter: 3 bits, counting 7 down to 0.

## Structure
- Package i2c_pkg holds:
  - the FSM state enum (shared with the slave tester's encoding width, 4 bits);
  - quarter-phase constants Q0..Q3;
  - I2C_ADDR_W=7 and I2C_DATA_W=8.
- Sub-module i2c_quarter_tick: parameterised divider producing a 1-clk tick and a 2-bit phase. Reset and enable come from the parent; it is held in reset while IDLE.
- The top-level wrapper converts the oe outputs to open-drain pads. This block contains no tri-states.

## Test plan
- Write with ACK: CLKS_PER_QUARTER=4, addr=0x08, rw=0, wr_data=0xA5, slave model ACKs.
  - SDA bit sequence 0001000_0, then 10100101.
  - done after 320 clks; ack_err=0.
- Address NACK: addr=0x55 with no responder.
  - ack_err=1 at done, 176 clks after accept.
  - No SCL pulses occur between ACK_A and STOP.
- Read: rw=1, slave drives 0x3C.
  - rd_data=0x3C at done.
  - Master leaves SDA released during the ACK_D slot.
- Protocol checker: SDA stable while SCL high except one START fall and one STOP rise per transaction. Check random addr/data over 200 transactions.
- start pulsed while busy=1: ignored, with latched addr unchanged. start held high: the second accept occurs exactly 1 clk after done.
- rst asserted during DATA bit 3: scl_oe=0, sda_oe=0 and busy=0 in the same clk, asynchronously. The next start runs a clean transaction.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C byte-master types: FSM state encoding, quarter phases, field widths,
// and the per-state SCL/SDA pull decode.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        ADDR  = 4'd2,
        ACK_A = 4'd3,
        DATA  = 4'd4,
        ACK_D = 4'd5,
        STOP  = 4'd6
    } i2c_state_t;

    // Returns {scl_oe, sda_oe}; sda_bit is the value to place on SDA in a driven bit slot.
    function automatic logic [1:0] bus_drive(i2c_state_t st, logic [1:0] q, logic sda_bit);
        logic [1:0] r;
        r = 2'b00;
        case (st)
            START:        r = {q == Q3, q >= Q2};
            ADDR, DATA:   r = {q <= Q1, ~sda_bit};
            ACK_A, ACK_D: r = {q <= Q1, 1'b0};
            STOP:         r = {q == Q0, q <= Q1};
            default:      r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2c_byte_master_if.sv
// Request/response and open-drain bus signals of the I2C byte master.
// The master modport is the block itself; slave is the requesting/bus-side environment.
interface i2c_byte_master_if;
    import i2c_pkg::*;

    logic                  start;
    logic [I2C_ADDR_W-1:0] addr;
    logic                  rw;
    logic [I2C_DATA_W-1:0] wr_data;
    logic                  busy;
    logic                  done;
    logic                  ack_err;
    logic [I2C_DATA_W-1:0] rd_data;
    logic                  scl_oe;
    logic                  sda_oe;
    logic                  sda_i;

    modport master (
        input  start, addr, rw, wr_data, sda_i,
        output busy, done, ack_err, rd_data, scl_oe, sda_oe
    );

    modport slave (
        output start, addr, rw, wr_data, sda_i,
        input  busy, done, ack_err, rd_data, scl_oe, sda_oe
    );

endinterface

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider: 1-clk tick on the last clock of each quarter plus a 2-bit phase.
// Held cleared while en=0 so the first quarter after enable is always a full Q0.
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int CLKS_PER_QUARTER = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int            CW   = (CLKS_PER_QUARTER > 1) ? $clog2(CLKS_PER_QUARTER) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_QUARTER - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP; no stretching.
// Accept-to-first-bus-quarter 1 clk; done 80 quarters after accept (44 on address NACK); start ignored while busy.
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter int CLKS_PER_QUARTER = 250
) (
    input logic               clk,
    input logic               rst,
    i2c_byte_master_if.master bus
);

    i2c_state_t            state, state_nxt;
    logic                  tick;
    logic [1:0]            phase, phase_nxt;
    logic                  slot_end, sample, accept;
    logic [I2C_DATA_W-1:0] tx_sr, tx_nxt, wr_byte, rd_byte;
    logic                  rw_q, ack_fail, done_q, scl_low, sda_low;
    logic [2:0]            bit_cnt;
    logic                  sda_bit_nxt;
    logic [1:0]            drv;

    i2c_quarter_tick #(.CLKS_PER_QUARTER(CLKS_PER_QUARTER)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (state != IDLE),
        .tick  (tick),
        .phase (phase)
    );

    assign slot_end = tick && (phase == Q3);
    assign sample   = tick && (phase == Q2);
    assign accept   = (state == IDLE) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start)                   state_nxt = START;
            START:   if (slot_end)                    state_nxt = ADDR;
            ADDR:    if (slot_end && bit_cnt == 3'd0) state_nxt = ACK_A;
            ACK_A:   if (slot_end)                    state_nxt = ack_fail ? STOP : DATA;
            DATA:    if (slot_end && bit_cnt == 3'd0) state_nxt = ACK_D;
            ACK_D:   if (slot_end)                    state_nxt = STOP;
            STOP:    if (slot_end)                    state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase

        tx_nxt = tx_sr;
        if (accept)
            tx_nxt = {bus.addr, bus.rw};
        else if (slot_end && (state == ADDR || state == DATA))
            tx_nxt = {tx_sr[I2C_DATA_W-2:0], 1'b1};
        else if (slot_end && state == ACK_A)
            tx_nxt = wr_byte;

        // Pads are registered from next-state values so they never glitch on decode.
        phase_nxt   = tick ? phase + 2'd1 : phase;
        sda_bit_nxt = (state_nxt == DATA && rw_q) ? 1'b1 : tx_nxt[I2C_DATA_W-1];
        drv         = bus_drive(state_nxt, phase_nxt, sda_bit_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr    <= '0;
            wr_byte  <= '0;
            rd_byte  <= '0;
            rw_q     <= 1'b0;
            ack_fail <= 1'b0;
            bit_cnt  <= 3'd7;
            done_q   <= 1'b0;
            scl_low  <= 1'b0;
            sda_low  <= 1'b0;
        end else begin
            tx_sr              <= tx_nxt;
            {scl_low, sda_low} <= drv;
            done_q             <= (state == STOP) && (state_nxt == IDLE);

            if (state != ADDR && state != DATA) bit_cnt <= 3'd7;
            else if (slot_end)                  bit_cnt <= bit_cnt - 3'd1;

            if (accept) begin
                wr_byte  <= bus.wr_data;
                rw_q     <= bus.rw;
                ack_fail <= 1'b0;
                rd_byte  <= '0;
            end else if (sample) begin
                case (state)
                    ACK_A:   ack_fail <= bus.sda_i;
                    DATA:    if (rw_q)  rd_byte  <= {rd_byte[I2C_DATA_W-2:0], bus.sda_i};
                    ACK_D:   if (!rw_q) ack_fail <= bus.sda_i;
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.ack_err = ack_fail;
    assign bus.rd_data = rd_byte;
    assign bus.scl_oe  = scl_low;
    assign bus.sda_oe  = sda_low;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: behavioural I2C target and line monitor plus directed and random transactions.
module tb_i2c_byte_master;
    import i2c_pkg::*;

    localparam int CQ = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_byte_master_if bus ();

    i2c_byte_master #(.CLKS_PER_QUARTER(CQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests;
    int n_fail;

    // Target configuration, written only by the stimulus block.
    logic       s_en, s_dack;
    logic [6:0] s_addr;
    logic [7:0] s_tx;

    // Target / monitor state, written only by the monitor block.
    logic       s_pull = 1'b0;
    logic       s_active, s_match, s_read;
    logic [7:0] s_shift;
    int         s_bits;
    logic       bits [1:32];
    int         n_start = 0, n_stop = 0, n_rise = 0;
    logic       scl_p, sda_p;

    wire scl_line = ~bus.scl_oe;
    wire sda_line = ~(bus.sda_oe | s_pull);
    assign bus.sda_i = sda_line;

    // Line-level target: decodes START/STOP and bit clocks, ACKs its address, serves read data.
    always @(negedge clk) begin : mon
        logic scl_now, sda_now;
        scl_now = scl_line;
        sda_now = sda_line;
        if (rst) begin
            s_pull   = 1'b0;
            s_active = 1'b0;
            s_bits   = 0;
            scl_p    = 1'b1;
            sda_p    = 1'b1;
        end else begin
            if (scl_p && scl_now && (sda_p !== sda_now)) begin
                if (!sda_now) begin
                    n_start++;
                    s_active = 1'b1;
                    s_bits   = 0;
                    s_shift  = 8'h00;
                end else begin
                    n_stop++;
                    s_active = 1'b0;
                end
                s_pull = 1'b0;
            end else if (!scl_p && scl_now) begin
                n_rise++;
                if (s_active) begin
                    s_bits++;
                    if (s_bits <= 32) bits[s_bits] = sda_now;
                    if (s_bits <= 8)  s_shift = {s_shift[6:0], sda_now};
                end
            end else if (scl_p && !scl_now && s_active) begin
                if (s_bits == 8) begin
                    s_match = s_en && (s_shift[7:1] == s_addr);
                    s_read  = s_shift[0];
                    s_pull  = s_match;
                end else if (s_bits >= 9 && s_bits <= 16) begin
                    s_pull = s_match && s_read && !s_tx[16 - s_bits];
                end else if (s_bits == 17) begin
                    s_pull = s_match && !s_read && s_dack;
                end else begin
                    s_pull = 1'b0;
                end
            end
            scl_p = scl_now;
            sda_p = sda_now;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction from request to done; poke re-requests mid-transfer, keep leaves start high.
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                           input bit poke, input bit keep);
        int         cyc, st0, sp0, rs0, exp_len;
        logic       addr_ok, exp_err;
        logic [7:0] exp_rd, got8;

        addr_ok = s_en && (s_addr == a);
        exp_err = !addr_ok || (!r && !s_dack);
        exp_rd  = (addr_ok && r) ? s_tx : 8'h00;
        exp_len = addr_ok ? 80 * CQ : 44 * CQ;
        st0 = n_start; sp0 = n_stop; rs0 = n_rise;

        bus.addr = a; bus.rw = r; bus.wr_data = d; bus.start = 1'b1;
        @(posedge clk); #1;
        if (!keep) bus.start = 1'b0;
        chk("busy_after_accept", bus.busy, 1);

        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 40) begin
                bus.start = 1'b1; bus.addr = ~a; bus.rw = ~r; bus.wr_data = ~d;
            end
            if (poke && cyc == 41) bus.start = 1'b0;
        end

        chk("txn_length", cyc, exp_len);
        chk("busy_at_done", bus.busy, 0);
        chk("ack_err", bus.ack_err, exp_err);
        chk("rd_data", bus.rd_data, exp_rd);
        chk("start_count", n_start - st0, 1);
        chk("stop_count", n_stop - sp0, 1);
        chk("scl_rises", n_rise - rs0, addr_ok ? 19 : 10);

        got8 = 8'h00;
        for (int k = 1; k <= 8; k++) got8 = {got8[6:0], bits[k]};
        chk("addr_bits", got8, {a, r});
        chk("ack_a_bit", bits[9], !addr_ok);
        if (addr_ok) begin
            got8 = 8'h00;
            for (int k = 10; k <= 17; k++) got8 = {got8[6:0], bits[k]};
            chk("data_bits", got8, r ? s_tx : d);
            chk("ack_d_bit", bits[18], r ? 1'b1 : !s_dack);
        end

        if (!keep) begin
            @(posedge clk); #1;
            chk("done_one_cycle", bus.done, 0);
        end
    endtask

    initial begin
        logic [6:0] ra;
        logic       rr;
        logic [7:0] rd;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.addr = '0; bus.rw = 1'b0; bus.wr_data = '0;
        s_en = 1'b0; s_addr = '0; s_dack = 1'b0; s_tx = '0;

        repeat (3) @(posedge clk); #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ack_err", bus.ack_err, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_scl_oe", bus.scl_oe, 0);
        chk("rst_sda_oe", bus.sda_oe, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        s_en = 1'b1; s_addr = 7'h08; s_dack = 1'b1; s_tx = 8'h00;
        run_txn(7'h08, 1'b0, 8'hA5, 0, 0);

        s_en = 1'b0;
        run_txn(7'h55, 1'b0, 8'h12, 0, 0);

        s_en = 1'b1; s_addr = 7'h2A; s_tx = 8'h3C;
        run_txn(7'h2A, 1'b1, 8'h00, 0, 0);

        s_dack = 1'b0;
        run_txn(7'h2A, 1'b0, 8'h5A, 0, 0);

        s_dack = 1'b1;
        run_txn(7'h2A, 1'b0, 8'hC3, 1, 0);

        s_tx = 8'h96;
        run_txn(7'h2A, 1'b1, 8'h00, 0, 1);
        chk("b2b_done_high", bus.done, 1);
        run_txn(7'h2A, 1'b0, 8'h71, 0, 0);

        // Asynchronous reset in the middle of DATA bit 3 of a write.
        bus.addr = 7'h2A; bus.rw = 1'b0; bus.wr_data = 8'hA5; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (225) @(posedge clk); #1;
        chk("pre_rst_scl", bus.scl_oe, 1);
        chk("pre_rst_sda", bus.sda_oe, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_scl", bus.scl_oe, 0);
        chk("mid_rst_sda", bus.sda_oe, 0);
        chk("mid_rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_txn(7'h2A, 1'b0, 8'h3E, 0, 0);

        for (int i = 0; i < 200; i++) begin
            ra     = 7'($urandom);
            rr     = 1'($urandom);
            rd     = 8'($urandom);
            s_en   = ($urandom_range(0, 3) != 0);
            s_addr = ($urandom_range(0, 3) != 0) ? ra : (ra ^ 7'($urandom_range(1, 127)));
            s_dack = ($urandom_range(0, 4) != 0);
            s_tx   = 8'($urandom);
            run_txn(ra, rr, rd, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
